// File: rtl/fetch_unit.sv
// fetch_unit -- single-outstanding instruction fetch front end.
//
// Issues one word request at a time to instruction memory, captures the
// returned word, and holds it for the decoder until the core takes it.
// The next PC is chosen on the handoff cycle: the redirect target when
// redirect_valid is set, otherwise pc+4 (wrapping modulo 2^32).
//
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap a handoff whose
// redirect target is not word aligned. The unit then parks in a fault
// state, raises fetch_fault and stops fetching until reset. Without the
// macro the target's low two bits are cleared and fetching continues.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   imem_req_*        request channel (valid/ready/addr) to instruction memory
//   imem_rsp_*        response channel (valid/data) from instruction memory
//   instr_valid/ready held instruction handshake with the core
//   instr, opcode     held instruction word and its [6:0] field
//   instr_pc          address of the held instruction
//   redirect_valid/pc next-PC override, sampled only on handoff
//   retired_count     number of instructions handed off (wraps)
//   fetch_fault       misaligned redirect trapped (FETCH_MISALIGN_TRAP_EN only)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        fetch_fault,
`endif
  output logic [31:0] retired_count
);

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [1:0] S_FAULT = 2'd3;
`endif

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic [31:0] retired_q;
  // Cleared by reset and set on the first clock afterwards, so the request
  // is held off while reset is asserted without gating an output by an input.
  logic        live;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fault_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      retired_q  <= 32'h0;
      live       <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      live <= 1'b1;
      case (state)
        S_REQ: begin
          if (live && imem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            instr_q    <= imem_rsp_data;
            instr_pc_q <= pc;
            state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            retired_q <= retired_q + 32'd1;
            state     <= S_REQ;
            if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
              pc <= redirect_pc;
              if (redirect_pc[1:0] != 2'b00) begin
                fault_q <= 1'b1;
                state   <= S_FAULT;
              end
`else
              pc <= redirect_pc & ~32'h3;
`endif
            end else begin
              pc <= pc + 32'd4;
            end
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        S_FAULT: state <= S_FAULT;
`endif
        default: state <= S_REQ;
      endcase
    end
  end

  assign imem_req_valid = live && (state == S_REQ);
  assign imem_req_addr  = pc;
  assign instr_valid    = (state == S_HOLD);
  assign instr          = instr_q;
  assign opcode         = instr_q[6:0];
  assign instr_pc       = instr_pc_q;
  assign retired_count  = retired_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_fault    = fault_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- table vectors, hand sequences and a randomized run checked
// against a transaction-level model of the fetch unit.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_ready, rsp_valid, instr_ready, rv;
  logic [31:0] rsp_data, rpc;

  logic        req_valid, ivalid;
  logic [31:0] req_addr, instr, ipc, retired;
  logic [6:0]  opcode;
  logic        d2_req_valid, d2_ivalid;
  logic [31:0] d2_req_addr, d2_instr, d2_ipc, d2_retired;
  logic [6:0]  d2_opcode;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fault, d2_fault;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .instr_valid(ivalid), .instr_ready(instr_ready), .instr(instr), .opcode(opcode),
    .instr_pc(ipc), .redirect_valid(rv), .redirect_pc(rpc),
`ifdef FETCH_MISALIGN_TRAP_EN
    .fetch_fault(fault),
`endif
    .retired_count(retired)
  );

  // Second instance shares all stimulus; only its addresses differ.
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(reset),
    .imem_req_valid(d2_req_valid), .imem_req_ready(req_ready), .imem_req_addr(d2_req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .instr_valid(d2_ivalid), .instr_ready(instr_ready), .instr(d2_instr), .opcode(d2_opcode),
    .instr_pc(d2_ipc), .redirect_valid(rv), .redirect_pc(rpc),
`ifdef FETCH_MISALIGN_TRAP_EN
    .fetch_fault(d2_fault),
`endif
    .retired_count(d2_retired)
  );

  int total = 0, passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic idle();
    req_ready = 0; rsp_valid = 0; rsp_data = 0; instr_ready = 0; rv = 0; rpc = 0;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk); reset = 1;
    @(negedge clk);
    chk("rst_req_valid", 32'(req_valid), 0);
    chk("rst_instr_valid", 32'(ivalid), 0);
    chk("rst_retired", retired, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", ipc, 0);
    reset = 0;
    @(negedge clk);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (req_valid) return;
      @(negedge clk);
    end
    chk("req_timeout", 32'(req_valid), 1);
  endtask

  // One full transaction: accept, respond next cycle, hand off next cycle.
  task automatic fetch(input logic [31:0] data, input logic rv_i, input logic [31:0] rpc_i,
                       input logic [31:0] exp_ipc, input logic [6:0] exp_op);
    wait_req();
    req_ready = 1;
    @(negedge clk);
    req_ready = 0;
    chk("wait_no_req", 32'(req_valid), 0);
    rsp_valid = 1; rsp_data = data;
    @(negedge clk);
    rsp_valid = 0; rsp_data = 0;
    chk("hold_valid", 32'(ivalid), 1);
    chk("hold_instr", instr, data);
    chk("hold_opcode", 32'(opcode), 32'(exp_op));
    chk("hold_instr_pc", ipc, exp_ipc);
    instr_ready = 1; rv = rv_i; rpc = rpc_i;
    @(negedge clk);
    idle();
  endtask

  typedef struct {
    logic [31:0] data;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] exp_ipc;
    logic [6:0]  exp_op;
    logic [31:0] exp_next;
  } vec_t;
  vec_t tbl[4];

  // Transaction-level reference: next fetch address, at most one request in
  // flight, at most one captured word waiting for the core.
  logic [31:0] m_pc, m_cnt;
  logic        m_out;
  logic [63:0] m_held[$];

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h0000_0013, 1'b0, 32'h0,   32'h0,   7'h13, 32'h4};
    tbl[1] = '{32'h00a0_0093, 1'b1, 32'h100, 32'h4,   7'h13, 32'h100};
    tbl[2] = '{32'h0000_006f, 1'b1, 32'h40,  32'h100, 7'h6f, 32'h40};
    tbl[3] = '{32'h0000_0063, 1'b0, 32'h0,   32'h40,  7'h63, 32'h44};

    reset = 1;
    do_reset();
    chk("first_req_valid", 32'(req_valid), 1);
    chk("first_req_addr", req_addr, 0);
    chk("d2_first_addr", d2_req_addr, 32'hFFFF_FFFC);

    // Memory stalls; stray responses while requesting must be ignored.
    for (int i = 0; i < 5; i++) begin
      rsp_valid = (i % 2 == 0); rsp_data = 32'hBAD0_0000;
      @(negedge clk);
      chk("stall_req_valid", 32'(req_valid), 1);
      chk("stall_addr", req_addr, 0);
      chk("stall_no_capture", 32'(ivalid), 0);
    end
    idle();

    for (int i = 0; i < 4; i++) begin
      fetch(tbl[i].data, tbl[i].rv, tbl[i].rpc, tbl[i].exp_ipc, tbl[i].exp_op);
      chk("next_addr", req_addr, tbl[i].exp_next);
      chk("retired", retired, 32'(i + 1));
      if (i == 0) chk("d2_wrap_addr", d2_req_addr, 32'h0);
    end

    // Core stalls in hold; redirect and responses outside handoff are ignored.
    wait_req();
    req_ready = 1; @(negedge clk);
    req_ready = 0; rsp_valid = 1; rsp_data = 32'h1234_5033; @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rsp_valid = 1; rsp_data = 32'hFFFF_FFFF; rv = 1; rpc = 32'h800;
      @(negedge clk);
      chk("stall_hold_valid", 32'(ivalid), 1);
      chk("stall_hold_noreq", 32'(req_valid), 0);
      chk("stall_hold_instr", instr, 32'h1234_5033);
    end
    idle(); instr_ready = 1; @(negedge clk); idle();
    chk("after_stall_addr", req_addr, 32'h48);

    // Reset in the middle of a wait, then a stale response arrives.
    wait_req();
    req_ready = 1; @(negedge clk);
    req_ready = 0; reset = 1; #1;
    chk("midwait_rst_req", 32'(req_valid), 0);
    chk("midwait_rst_ret", retired, 0);
    @(negedge clk); reset = 0;
    @(negedge clk);
    chk("post_rst_addr", req_addr, 0);
    rsp_valid = 1; rsp_data = 32'h0000_0013;
    @(negedge clk); idle();
    chk("stale_no_capture", 32'(ivalid), 0);
    chk("stale_req_valid", 32'(req_valid), 1);
    chk("stale_ret", retired, 0);

    // Misaligned redirect.
    fetch(32'h0000_0067, 1'b1, 32'h42, 32'h0, 7'h67);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("fault_set", 32'(fault), 1);
    for (int i = 0; i < 3; i++) begin
      req_ready = 1; @(negedge clk);
      chk("fault_noreq", 32'(req_valid), 0);
      chk("fault_noinstr", 32'(ivalid), 0);
    end
    do_reset();
    chk("fault_cleared", 32'(fault), 0);
`else
    chk("misalign_addr", req_addr, 32'h40);
`endif

    // Randomized run against the reference model.
    do_reset();
    m_pc = 0; m_cnt = 0; m_out = 0; m_held.delete();
    for (int c = 0; c < 600; c++) begin
      logic exp_req;
      exp_req = !m_out && (m_held.size() == 0);
      chk("rnd_req_valid", 32'(req_valid), 32'(exp_req));
      if (exp_req) chk("rnd_addr", req_addr, m_pc);
      chk("rnd_instr_valid", 32'(ivalid), 32'(m_held.size() == 1));
      if (m_held.size() == 1) begin
        chk("rnd_instr", instr, m_held[0][31:0]);
        chk("rnd_instr_pc", ipc, m_held[0][63:32]);
      end
      chk("rnd_retired", retired, m_cnt);

      req_ready   = ($urandom_range(0, 2) != 0);
      rsp_valid   = ($urandom_range(0, 2) != 0);
      rsp_data    = $urandom();
      instr_ready = ($urandom_range(0, 1) != 0);
      rv          = ($urandom_range(0, 3) == 0);
`ifdef FETCH_MISALIGN_TRAP_EN
      rpc         = $urandom() & ~32'h3;
`else
      rpc         = $urandom();
`endif
      if (exp_req && req_ready) m_out = 1;
      else if (m_out && rsp_valid) begin
        m_held.push_back({m_pc, rsp_data});
        m_out = 0;
      end else if (m_held.size() == 1 && instr_ready) begin
        m_cnt = m_cnt + 1;
        m_pc  = rv ? (rpc & ~32'h3) : m_pc + 32'd4;
        void'(m_held.pop_front());
      end
      @(negedge clk);
    end
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
